// File: rtl/apb_master.sv
// Single-outstanding APB requester: turns a valid/ready command into a SETUP/ACCESS transfer
// and returns read data plus error/timeout status on a valid/ready response channel.
module apb_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic                    cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pprot,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ALIGN_BITS = $clog2(STRB_WIDTH);
  localparam int unsigned CNT_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
      ~ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  // Counter value in the last allowed wait cycle; hitting it without pready aborts.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pprot_q, pprot_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    slverr_q, slverr_d;
  logic                    timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    accept;
  logic                    timeout_hit;

  assign cmd_ready   = (state_q == StIdle) && !reset;
  assign accept      = cmd_valid && cmd_ready;
  assign timeout_hit = (TIMEOUT != 0) && (state_q == StAccess) && !pready && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      paddr_q   <= '0;
      pprot_q   <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pprot_q   <= pprot_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (pready || timeout_hit) state_d = StResp;
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    paddr_d   = paddr_q;
    pprot_d   = pprot_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    slverr_d  = slverr_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          paddr_d  = cmd_addr & ADDR_MASK;
          pprot_d  = cmd_prot;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          cnt_d    = '0;
        end
      end
      StAccess: begin
        if (pready) begin
          rdata_d   = pwrite_q ? '0 : prdata;
          slverr_d  = pslverr;
          timeout_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (timeout_hit) begin
            rdata_d   = '0;
            slverr_d  = 1'b1;
            timeout_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign psel        = (state_q == StSetup) || (state_q == StAccess);
  assign penable     = (state_q == StAccess);
  assign rsp_valid   = (state_q == StResp);
  assign paddr       = paddr_q;
  assign pprot       = pprot_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_slverr  = slverr_q;
  assign rsp_timeout = timeout_q;

endmodule
